// File: rtl/lighting_pkg.sv
// +--------------------------------------------------------------------+
// | lighting_pkg: shared zone state encoding, defaults, RR search      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package lighting_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ON   = 2'b10,
        OVR  = 2'b11
    } zone_state_t;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_MAX_ON      = 2;
    localparam int MAX_ZONES       = 8;
    localparam int PTR_W           = 3;

    // Returns {found, index} of the first set bit at or after ptr, wrapping modulo n.
    function automatic logic [PTR_W:0] rr_first(
        input logic [MAX_ZONES-1:0] req,
        input logic [PTR_W-1:0]     ptr,
        input int                   n
    );
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int i = MAX_ZONES - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % n;
            if (i < n && req[idx]) begin
                res = {1'b1, PTR_W'(idx)};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lighting_zone_timer.sv
// +--------------------------------------------------------------------+
// | lighting_zone_timer: per-zone hold countdown, expired at zero       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module lighting_zone_timer #(
    parameter int TIMER_W     = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= TIMER_W'(HOLD_CYCLES - 1);
        end else if (dec && r_count != '0) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/lighting_zone_arbiter.sv
// +--------------------------------------------------------------------+
// | lighting_zone_arbiter: occupancy lighting with shared lamp budget, |
// | round-robin slot grants; LIGHT_STARVE_FLAG_EN adds starve_flag.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module lighting_zone_arbiter
    import lighting_pkg::*;
#(
    parameter int NUM_ZONES   = 4,
    parameter int MAX_ON      = DEF_MAX_ON,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TIMER_W     = 8
`ifdef LIGHT_STARVE_FLAG_EN
    ,
    parameter int STARVE_CYCLES = 64
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_ZONES-1:0]             motion_detected,
    input  logic [NUM_ZONES-1:0]             manual_override,
    output logic [NUM_ZONES-1:0]             light_on,
    output logic [NUM_ZONES-1:0]             zone_waiting,
`ifdef LIGHT_STARVE_FLAG_EN
    output logic [NUM_ZONES-1:0]             starve_flag,
`endif
    output logic [$clog2(NUM_ZONES+1)-1:0]   active_count
);

    localparam int CNT_W = $clog2(NUM_ZONES + 1);

    zone_state_t            r_state  [NUM_ZONES];
    zone_state_t            w_state_nxt [NUM_ZONES];
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_rr_ptr_nxt;
    logic [NUM_ZONES-1:0]   r_light_on;
    logic [NUM_ZONES-1:0]   r_zone_waiting;
    logic [CNT_W-1:0]       r_active_count;

    logic [NUM_ZONES-1:0]   w_cand;
    logic [MAX_ZONES-1:0]   w_req8;
    logic [PTR_W:0]         w_pick;
    logic                   w_grant_any;
    logic [NUM_ZONES-1:0]   w_grant;
    logic [NUM_ZONES-1:0]   w_load;
    logic [NUM_ZONES-1:0]   w_dec;
    logic [NUM_ZONES-1:0]   w_expired;
    logic [NUM_ZONES-1:0]   w_light_nxt;
    logic [NUM_ZONES-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]       w_count_nxt;

    always_comb begin
        w_cand       = '0;
        w_req8       = '0;
        w_grant      = '0;
        w_load       = '0;
        w_dec        = '0;
        w_light_nxt  = '0;
        w_wait_nxt   = '0;
        w_count_nxt  = '0;
        w_rr_ptr_nxt = r_rr_ptr;

        for (int z = 0; z < NUM_ZONES; z++) begin
            w_cand[z] = !manual_override[z] &&
                        (r_state[z] == WAIT || (r_state[z] == IDLE && motion_detected[z]));
            w_req8[z] = w_cand[z];
        end

        // Budget test uses the registered count, so a freed slot is reusable one edge later.
        w_pick      = rr_first(w_req8, r_rr_ptr, NUM_ZONES);
        w_grant_any = w_pick[PTR_W] && (r_active_count < CNT_W'(MAX_ON));
        if (w_grant_any) begin
            w_rr_ptr_nxt = (int'(w_pick[PTR_W-1:0]) == NUM_ZONES - 1) ? '0
                                                                      : w_pick[PTR_W-1:0] + PTR_W'(1);
        end

        for (int z = 0; z < NUM_ZONES; z++) begin
            w_grant[z]     = w_grant_any && (w_pick[PTR_W-1:0] == PTR_W'(z));
            w_state_nxt[z] = r_state[z];
            if (manual_override[z]) begin
                w_state_nxt[z] = OVR;
            end else begin
                case (r_state[z])
                    IDLE: if (motion_detected[z]) w_state_nxt[z] = w_grant[z] ? ON : WAIT;
                    WAIT: if (w_grant[z]) w_state_nxt[z] = ON;
                    ON: begin
                        if (motion_detected[z]) begin
                            w_load[z] = 1'b1;
                        end else if (!w_expired[z]) begin
                            w_dec[z] = 1'b1;
                        end else begin
                            w_state_nxt[z] = IDLE;
                        end
                    end
                    default: w_state_nxt[z] = IDLE;
                endcase
                if (w_grant[z]) w_load[z] = 1'b1;
            end
            w_light_nxt[z] = (w_state_nxt[z] == ON) || (w_state_nxt[z] == OVR);
            w_wait_nxt[z]  = (w_state_nxt[z] == WAIT);
            if (w_state_nxt[z] == ON) w_count_nxt = w_count_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int z = 0; z < NUM_ZONES; z++) r_state[z] <= IDLE;
            r_rr_ptr       <= '0;
            r_light_on     <= '0;
            r_zone_waiting <= '0;
            r_active_count <= '0;
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) r_state[z] <= w_state_nxt[z];
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_light_on     <= w_light_nxt;
            r_zone_waiting <= w_wait_nxt;
            r_active_count <= w_count_nxt;
        end
    end

    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
        lighting_zone_timer #(
            .TIMER_W     (TIMER_W),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_timer (
            .clk     (clk),
            .reset   (reset),
            .load    (w_load[g]),
            .dec     (w_dec[g]),
            .expired (w_expired[g])
        );
    end

`ifdef LIGHT_STARVE_FLAG_EN
    localparam int SC_W = $clog2(STARVE_CYCLES + 1);

    logic [SC_W-1:0]      r_wait_cnt [NUM_ZONES];
    logic [SC_W-1:0]      w_wait_cnt_nxt [NUM_ZONES];
    logic [NUM_ZONES-1:0] r_starve;

    always_comb begin
        for (int z = 0; z < NUM_ZONES; z++) begin
            w_wait_cnt_nxt[z] = '0;
            if (r_state[z] == WAIT && w_state_nxt[z] == WAIT) begin
                w_wait_cnt_nxt[z] = (r_wait_cnt[z] >= SC_W'(STARVE_CYCLES)) ? r_wait_cnt[z]
                                                                            : r_wait_cnt[z] + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int z = 0; z < NUM_ZONES; z++) r_wait_cnt[z] <= '0;
            r_starve <= '0;
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                r_wait_cnt[z] <= w_wait_cnt_nxt[z];
                r_starve[z]   <= (w_state_nxt[z] == WAIT) &&
                                 (w_wait_cnt_nxt[z] >= SC_W'(STARVE_CYCLES));
            end
        end
    end

    assign starve_flag = r_starve;
`endif

    assign light_on     = r_light_on;
    assign zone_waiting = r_zone_waiting;
    assign active_count = r_active_count;

endmodule

`default_nettype wire

// File: tb/tb_lighting_zone_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_lighting_zone_arbiter: directed self-checking bench, 4 zones    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_lighting_zone_arbiter;

    localparam int NZ = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NZ-1:0] motion_detected;
    logic [NZ-1:0] manual_override;
    logic [NZ-1:0] light_on;
    logic [NZ-1:0] zone_waiting;
    logic [2:0]    active_count;
`ifdef LIGHT_STARVE_FLAG_EN
    logic [NZ-1:0] starve_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int on_cnt;
    int off_cnt;

    lighting_zone_arbiter #(
        .NUM_ZONES   (NZ),
        .MAX_ON      (2),
        .HOLD_CYCLES (16),
        .TIMER_W     (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .motion_detected (motion_detected),
        .manual_override (manual_override),
        .light_on        (light_on),
        .zone_waiting    (zone_waiting),
`ifdef LIGHT_STARVE_FLAG_EN
        .starve_flag     (starve_flag),
`endif
        .active_count    (active_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        motion_detected = '0;
        manual_override = '0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        motion_detected = 4'($urandom);
        manual_override = 4'($urandom);

        // 1: reset with random inputs, then idle
        step();
        motion_detected = 4'($urandom);
        manual_override = 4'($urandom);
        step();
        check("rst_light", 32'(light_on), 0);
        check("rst_wait", 32'(zone_waiting), 0);
        check("rst_count", 32'(active_count), 0);
        reset = 1'b0;
        motion_detected = '0;
        manual_override = '0;
        step();
        step();
        check("idle_light", 32'(light_on), 0);
        check("idle_count", 32'(active_count), 0);

        // 2: single-cycle pulse gives exactly 16 lit cycles
        motion_detected = 4'b0001;
        step();
        motion_detected = '0;
        check("pulse_light", 32'(light_on), 32'h1);
        check("pulse_count", 32'(active_count), 1);
        on_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (light_on[0]) on_cnt++;
        end
        check("pulse_hold", 32'(on_cnt), 15);
        step();
        check("pulse_off", 32'(light_on), 0);
        check("pulse_count0", 32'(active_count), 0);

        // 3: three simultaneous requesters, budget of two
        do_reset();
        motion_detected = 4'b0111;
        step();
        motion_detected = '0;
        check("q_e0_light", 32'(light_on), 32'h1);
        check("q_e0_wait", 32'(zone_waiting), 32'h6);
        check("q_e0_count", 32'(active_count), 1);
        step();
        check("q_e1_light", 32'(light_on), 32'h3);
        check("q_e1_wait", 32'(zone_waiting), 32'h4);
        check("q_e1_count", 32'(active_count), 2);
        off_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (light_on != 4'b0011 || zone_waiting != 4'b0100) off_cnt++;
        end
        check("q_hold", 32'(off_cnt), 0);
        step();
        check("q_e16_light", 32'(light_on), 32'h2);
        check("q_e16_wait", 32'(zone_waiting), 32'h4);
        check("q_e16_count", 32'(active_count), 1);
        step();
        check("q_e17_light", 32'(light_on), 32'h4);
        check("q_e17_wait", 32'(zone_waiting), 0);
        check("q_e17_count", 32'(active_count), 1);

        // 4: retriggered motion keeps zone1 lit
        do_reset();
        off_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            motion_detected = (i % 10 == 0) ? 4'b0010 : 4'b0000;
            step();
            if (!light_on[1]) off_cnt++;
        end
        motion_detected = '0;
        check("retrig_cont", 32'(off_cnt), 0);
        on_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (light_on[1]) on_cnt++;
        end
        check("retrig_tail", 32'(on_cnt), 6);
        step();
        check("retrig_off", 32'(light_on), 0);

        // 5: override outside the budget and override freeing a slot
        do_reset();
        motion_detected = 4'b0011;
        step();
        step();
        motion_detected = '0;
        check("ovr_base_light", 32'(light_on), 32'h3);
        manual_override = 4'b1000;
        step();
        check("ovr3_light", 32'(light_on), 32'hB);
        check("ovr3_count", 32'(active_count), 2);
        motion_detected = 4'b0100;
        step();
        motion_detected = '0;
        check("ovr_z2_wait", 32'(zone_waiting), 32'h4);
        manual_override = 4'b1001;
        step();
        check("ovr0_count", 32'(active_count), 1);
        check("ovr0_wait", 32'(zone_waiting), 32'h4);
        step();
        check("ovr_grant_light", 32'(light_on), 32'hF);
        check("ovr_grant_wait", 32'(zone_waiting), 0);
        check("ovr_grant_count", 32'(active_count), 2);
        manual_override = '0;
        step();
        check("ovr_rel_light", 32'(light_on), 32'h6);

        // 6: asynchronous reset mid-hold, then pointer restarts at zone0
        do_reset();
        motion_detected = 4'b0111;
        step();
        motion_detected = '0;
        step();
        step();
        reset = 1'b1;
        #2;
        check("arst_light", 32'(light_on), 0);
        check("arst_wait", 32'(zone_waiting), 0);
        check("arst_count", 32'(active_count), 0);
        step();
        reset = 1'b0;
        step();
        motion_detected = 4'b1001;
        step();
        motion_detected = '0;
        check("ptr0_light", 32'(light_on), 32'h1);
        check("ptr0_wait", 32'(zone_waiting), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
